// File: rtl/chan_err_inj_pkg.sv
// ============================================================================
// Module   : chan_pkg
// Brief    : Shared types and helpers for the channel error injector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package chan_pkg;

    typedef enum logic [1:0] {
        CH_CLEAN    = 2'b00,
        CH_PERIODIC = 2'b01,
        CH_RANDOM   = 2'b10,
        CH_BURST    = 2'b11
    } ch_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_BURST = 2'b10,
        ST_DONE  = 2'b11
    } ch_state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] w_sum;
        w_sum = {1'b0, a} + {15'd0, b};
        return w_sum[16] ? 16'hFFFF : w_sum[15:0];
    endfunction

    function automatic logic [1:0] popcount2(input logic [1:0] m);
        return {1'b0, m[1]} + {1'b0, m[0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/chan_err_inj_if.sv
// ============================================================================
// Module   : chan_err_inj_if
// Brief    : Symbol stream between encoder, channel model and decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface chan_err_inj_if;
    logic       enable_i;
    logic [1:0] d_in;
    logic       valid_o;
    logic [1:0] d_out;
    logic       err_flag_o;

    modport master (output enable_i, d_in, input valid_o, d_out, err_flag_o);
    modport slave  (input enable_i, d_in, output valid_o, d_out, err_flag_o);
endinterface

`default_nettype wire

// File: rtl/chan_err_inj_lfsr16.sv
// ============================================================================
// Module   : lfsr16
// Brief    : 16-bit Fibonacci LFSR with enable and synchronous reload.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr16
    import chan_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        i_reload,
    input  wire logic        i_en,
    output logic [15:0]      o_state
);

    logic [15:0] r_state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= SEED;
        end else if (i_reload) begin
            r_state <= SEED;
        end else if (i_en) begin
            r_state <= {r_state[14:0], ^(r_state & c_LFSR_TAPS)};
        end
    end

    assign o_state = r_state;

endmodule

`default_nettype wire

// File: rtl/chan_err_inj.sv
// ============================================================================
// Module   : chan_err_inj
// Brief    : Registers encoder symbols and XOR-corrupts them per a selectable
//            periodic / random / burst pattern inside a bounded window.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module chan_err_inj
    import chan_pkg::*;
#(
    parameter int          N         = 4,
    parameter int          WINDOW    = 256,
    parameter int          BURST_LEN = 3,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        start_i,
    input  wire logic [1:0]  mode_i,
    input  wire logic [1:0]  mask_i,
    chan_err_inj_if.slave    sif,
    output logic [15:0]      sym_ct_o,
    output logic [15:0]      err_bit_ct_o,
    output logic             done_o
);

    localparam logic [15:0] c_LOW_MASK  = 16'((1 << N) - 1);
    localparam logic [15:0] c_WIN_LAST  = 16'(WINDOW - 1);
    localparam logic [15:0] c_BURST_REM = 16'(BURST_LEN - 1);

    ch_state_e   r_state, w_state_nxt;
    ch_mode_e    r_mode;
    logic [1:0]  r_mask;
    logic [15:0] r_rem, w_rem_nxt;
    logic [15:0] r_sym_ct, r_err_ct;
    logic        r_valid, r_err_flag;
    logic [1:0]  r_d_out;
    logic [15:0] w_lfsr;
    logic        w_adv, w_corrupt, w_trig_per, w_trig_rnd;

    // A start cycle never consumes a symbol index or an LFSR step
    assign w_adv      = sif.enable_i & ~start_i;
    assign w_trig_per = (r_sym_ct & c_LOW_MASK) == c_LOW_MASK;
    assign w_trig_rnd = (w_lfsr & c_LOW_MASK) == 16'd0;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .i_reload (start_i),
        .i_en     (w_adv),
        .o_state  (w_lfsr)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_corrupt   = 1'b0;
        case (r_state)
            ST_ARMED: begin
                if (w_adv) begin
                    case (r_mode)
                        CH_PERIODIC: w_corrupt = w_trig_per;
                        CH_RANDOM:   w_corrupt = w_trig_rnd;
                        CH_BURST: begin
                            if (w_trig_per) begin
                                w_corrupt = 1'b1;
                                if (BURST_LEN > 1) begin
                                    w_state_nxt = ST_BURST;
                                    w_rem_nxt   = c_BURST_REM;
                                end
                            end
                        end
                        default: w_corrupt = 1'b0;
                    endcase
                end
            end
            ST_BURST: begin
                if (w_adv) begin
                    w_corrupt = 1'b1;
                    w_rem_nxt = r_rem - 16'd1;
                    if (r_rem == 16'd1) begin
                        w_state_nxt = ST_ARMED;
                    end
                end
            end
            default: ;
        endcase
        // Last in-window symbol closes the window, truncating any burst
        if (w_adv && (r_state == ST_ARMED || r_state == ST_BURST) && r_sym_ct == c_WIN_LAST) begin
            w_state_nxt = ST_DONE;
        end
        if (start_i) begin
            w_state_nxt = ST_ARMED;
            w_rem_nxt   = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_mode     <= CH_CLEAN;
            r_mask     <= 2'b00;
            r_rem      <= 16'd0;
            r_sym_ct   <= 16'd0;
            r_err_ct   <= 16'd0;
            r_valid    <= 1'b0;
            r_err_flag <= 1'b0;
            r_d_out    <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_rem      <= w_rem_nxt;
            r_valid    <= sif.enable_i;
            r_err_flag <= w_corrupt;
            if (sif.enable_i) begin
                r_d_out <= sif.d_in ^ (w_corrupt ? r_mask : 2'b00);
            end
            if (start_i) begin
                r_mode   <= ch_mode_e'(mode_i);
                r_mask   <= mask_i;
                r_sym_ct <= 16'd0;
                r_err_ct <= 16'd0;
            end else if (w_adv && r_state != ST_IDLE) begin
                r_sym_ct <= sat_add16(r_sym_ct, 2'd1);
                if (w_corrupt) begin
                    r_err_ct <= sat_add16(r_err_ct, popcount2(r_mask));
                end
            end
        end
    end

    assign sif.valid_o    = r_valid;
    assign sif.d_out      = r_d_out;
    assign sif.err_flag_o = r_err_flag;
    assign sym_ct_o       = r_sym_ct;
    assign err_bit_ct_o   = r_err_ct;
    assign done_o         = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_chan_err_inj.sv
// ============================================================================
// Module   : tb_chan_err_inj
// Brief    : Scoreboard bench for chan_err_inj with directed symbol vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_chan_err_inj;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  mode_i;
    logic [1:0]  mask_i;
    logic [15:0] sym_ct_o;
    logic [15:0] err_bit_ct_o;
    logic        done_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    chan_err_inj_if sif();

    chan_err_inj dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .mask_i       (mask_i),
        .sif          (sif),
        .sym_ct_o     (sym_ct_o),
        .err_bit_ct_o (err_bit_ct_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every valid output must match the oldest expected symbol
    always @(negedge clk) begin
        if (sif.valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got d_out=%0h with empty scoreboard", sif.d_out);
            end else begin
                chk("sym_out", {sif.d_out, sif.err_flag_o}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sym(input logic [1:0] d, input logic cor, input logic [1:0] m);
        sif.enable_i = 1'b1;
        sif.d_in     = d;
        exp_q.push_back({d ^ (cor ? m : 2'b00), cor});
        tick();
        sif.enable_i = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] md, input logic [1:0] mk);
        start_i = 1'b1;
        mode_i  = md;
        mask_i  = mk;
        tick();
        start_i = 1'b0;
        mode_i  = 2'b00;
        mask_i  = 2'b00;
    endtask

    function automatic logic [15:0] lfsr_nx(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic run_random(output int flips);
        logic [15:0] lf;
        logic        cor;
        lf    = 16'hACE1;
        flips = 0;
        do_start(2'b10, 2'b11);
        for (int k = 0; k < 100; k++) begin
            cor = (lf[3:0] == 4'h0);
            sym(2'(k), cor, 2'b11);
            if (cor) flips++;
            lf = lfsr_nx(lf);
        end
        chk("rnd_sym_ct", sym_ct_o, 100);
        chk("rnd_err_ct", err_bit_ct_o, 2 * flips);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f1, f2;
        logic [1:0] last;
        rst = 1'b0; start_i = 1'b0; mode_i = 2'b00; mask_i = 2'b00;
        sif.enable_i = 1'b0; sif.d_in = 2'b00;
        repeat (3) tick();
        chk("rst_valid", sif.valid_o, 0);
        chk("rst_dout", sif.d_out, 0);
        chk("rst_errflag", sif.err_flag_o, 0);
        chk("rst_symct", sym_ct_o, 0);
        chk("rst_errct", err_bit_ct_o, 0);
        chk("rst_done", done_o, 0);
        rst = 1'b1;
        tick();

        // IDLE: clean pass-through, no counting
        sym(2'b10, 1'b0, 2'b00);
        sym(2'b01, 1'b0, 2'b00);
        chk("idle_symct", sym_ct_o, 0);

        // Periodic, mask 01, 64 symbols
        do_start(2'b01, 2'b01);
        for (int k = 0; k < 64; k++) sym(2'b00, (k % 16) == 15, 2'b01);
        chk("per_symct", sym_ct_o, 64);
        chk("per_errct", err_bit_ct_o, 4);
        chk("per_done", done_o, 0);

        // Periodic, mask 11, across the window boundary
        do_start(2'b01, 2'b11);
        for (int k = 0; k < 300; k++) begin
            sym(2'(k), (k < 256) && ((k % 16) == 15), 2'b11);
            if (k >= 253 && k <= 258) chk("win_done", done_o, (k >= 255) ? 1 : 0);
        end
        chk("win_symct", sym_ct_o, 300);
        chk("win_errct", err_bit_ct_o, 32);

        // Burst, mask 10, 40 symbols
        do_start(2'b11, 2'b10);
        for (int k = 0; k < 40; k++)
            sym(2'b01, (k >= 15 && k <= 17) || (k >= 31 && k <= 33), 2'b10);
        chk("burst_symct", sym_ct_o, 40);
        chk("burst_errct", err_bit_ct_o, 6);
        chk("burst_done", done_o, 0);

        // Clean with 1-on / 2-off enable gaps
        do_start(2'b00, 2'b11);
        for (int k = 0; k < 20; k++) begin
            last = 2'(k + 1);
            sym(last, 1'b0, 2'b00);
            for (int g = 0; g < 2; g++) begin
                tick();
                if (k < 3) begin
                    chk("gap_valid", sif.valid_o, 0);
                    chk("gap_hold", sif.d_out, last);
                    chk("gap_errflag", sif.err_flag_o, 0);
                end
            end
        end
        chk("clean_symct", sym_ct_o, 20);
        chk("clean_errct", err_bit_ct_o, 0);

        // start_i coincident with a symbol
        start_i = 1'b1; mode_i = 2'b01; mask_i = 2'b01;
        sif.enable_i = 1'b1; sif.d_in = 2'b11;
        exp_q.push_back({2'b11, 1'b0});
        tick();
        start_i = 1'b0; mode_i = 2'b00; mask_i = 2'b00; sif.enable_i = 1'b0;
        chk("costart_symct", sym_ct_o, 0);
        for (int k = 0; k < 16; k++) sym(2'b00, k == 15, 2'b01);
        chk("costart_symct16", sym_ct_o, 16);
        chk("costart_errct", err_bit_ct_o, 1);

        // Random mode against a reference LFSR
        run_random(f1);

        // Reset asserted in the middle of a burst
        do_start(2'b11, 2'b11);
        for (int k = 0; k < 17; k++) sym(2'b00, k >= 15, 2'b11);
        rst = 1'b0; sif.enable_i = 1'b1; sif.d_in = 2'b11;
        tick();
        sif.enable_i = 1'b0;
        chk("mid_rst_valid", sif.valid_o, 0);
        chk("mid_rst_dout", sif.d_out, 0);
        chk("mid_rst_errflag", sif.err_flag_o, 0);
        chk("mid_rst_symct", sym_ct_o, 0);
        chk("mid_rst_errct", err_bit_ct_o, 0);
        chk("mid_rst_done", done_o, 0);
        rst = 1'b1;
        tick();

        // Fresh start reproduces the same random sequence
        run_random(f2);
        chk("rnd_repeat", f2, f1);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
